// File: rtl/comm_pkg.sv
// Opcodes, frame byte-count helpers and controller state encoding for the mux command host.
package comm_pkg;

  localparam logic [2:0] COMM_READ_MASK  = 3'd1;
  localparam logic [2:0] COMM_READ_MAP   = 3'd2;
  localparam logic [2:0] COMM_WRITE_MASK = 3'd3;
  localparam logic [2:0] COMM_WRITE_MAP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REJECT,
    ST_TX_BYTE,
    ST_TX_WAIT,
    ST_RECV,
    ST_DONE
  } state_t;

  function automatic int mask_bytes(input int output_count);
    return output_count / 8;
  endfunction

  function automatic int map_bytes(input int output_count, input int input_count);
    return ($clog2(input_count) * output_count) / 8;
  endfunction

endpackage

// File: rtl/comm_host_timeout.sv
// Inter-byte watchdog: clear reloads TIMEOUT_CYCLES-1, enable counts down, expired flags zero.
// Single-cycle response to clear; a clear wins over a decrement in the same cycle.
module comm_host_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(TIMEOUT_CYCLES - 1);
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/comm_host.sv
// Host initiator: one register request -> cmd + LSB-first payload over uart_tx, N-byte reply from uart_rx.
// One transaction outstanding; req_ready only in IDLE; COMM_HOST_VERIFY_EN adds write readback compare.
module comm_host
  import comm_pkg::*;
#(
  parameter int          OUTPUT_COUNT   = 16,
  parameter int          INPUT_COUNT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int         SEL_WIDTH      = $clog2(INPUT_COUNT) * OUTPUT_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [SEL_WIDTH-1:0] req_data,
  output logic                 rsp_valid,
  output logic [SEL_WIDTH-1:0] rsp_data,
  output logic                 rsp_timeout,
  output logic                 rsp_error,
  output logic                 rsp_mismatch,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data
);

  localparam int MASK_BYTES = mask_bytes(OUTPUT_COUNT);
  localparam int MAP_BYTES  = map_bytes(OUTPUT_COUNT, INPUT_COUNT);
  localparam int CNT_W      = $clog2(MAP_BYTES + 2);

  state_t               state;
  logic [2:0]           op;
  logic [SEL_WIDTH-1:0] tx_shift;
  logic [CNT_W-1:0]     tx_cnt;
  logic [CNT_W-1:0]     rx_cnt;
  logic [CNT_W-1:0]     n_bytes;
  logic                 tx_skip;
  logic                 rx_ready_q;
  logic                 rx_edge;
  logic                 is_write;
  logic                 more_tx;
  logic                 tmr_clear;
  logic                 tmr_expired;
  logic                 accept;
  logic                 mismatch_now;
  logic [SEL_WIDTH-1:0] rsp_ins;

  assign accept   = req_valid && req_ready;
  assign rx_edge  = rx_ready && !rx_ready_q;
  assign is_write = (op == COMM_WRITE_MASK) || (op == COMM_WRITE_MAP);
  // Command byte is count 0, so payload remains while tx_cnt has not passed n_bytes.
  assign more_tx  = is_write && (tx_cnt <= n_bytes);

  assign tmr_clear = ((state == ST_TX_WAIT) && !tx_skip && tx_done && !more_tx) ||
                     ((state == ST_RECV) && rx_edge);

  always_comb begin
    rsp_ins = rsp_data;
    for (int k = 0; k < MAP_BYTES; k++) begin
      if (rx_cnt == CNT_W'(k)) rsp_ins[k*8 +: 8] = rx_data;
    end
  end

`ifdef COMM_HOST_VERIFY_EN
  logic [SEL_WIDTH-1:0] wr_data;
  logic [SEL_WIDTH-1:0] cmp_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data <= '0;
    end else if (accept) begin
      wr_data <= req_data;
    end
  end

  always_comb begin
    cmp_mask = '0;
    for (int k = 0; k < MAP_BYTES; k++) begin
      if (CNT_W'(k) < n_bytes) cmp_mask[k*8 +: 8] = 8'hFF;
    end
  end

  assign mismatch_now = is_write && (((rsp_ins ^ wr_data) & cmp_mask) != '0);
`else
  assign mismatch_now = 1'b0;
`endif

  comm_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (state == ST_RECV),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      op           <= '0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      n_bytes      <= '0;
      tx_skip      <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_mismatch <= 1'b0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op        <= req_op;
            tx_shift  <= req_data;
            rsp_data  <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            req_ready <= 1'b0;
            n_bytes   <= ((req_op == COMM_READ_MASK) || (req_op == COMM_WRITE_MASK)) ?
                         CNT_W'(MASK_BYTES) : CNT_W'(MAP_BYTES);
            if ((req_op >= COMM_READ_MASK) && (req_op <= COMM_WRITE_MAP)) begin
              state <= ST_TX_BYTE;
            end else begin
              state     <= ST_REJECT;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end
          end
        end

        ST_REJECT, ST_DONE: begin
          rsp_valid    <= 1'b0;
          rsp_error    <= 1'b0;
          rsp_timeout  <= 1'b0;
          rsp_mismatch <= 1'b0;
          req_ready    <= 1'b1;
          state        <= ST_IDLE;
        end

        ST_TX_BYTE: begin
          if (tx_done) begin
            tx_start <= 1'b1;
            tx_data  <= (tx_cnt == '0) ? {5'b0, op} : tx_shift[7:0];
            if (tx_cnt != '0) tx_shift <= tx_shift >> 8;
            tx_cnt   <= tx_cnt + CNT_W'(1);
            tx_skip  <= 1'b1;
            state    <= ST_TX_WAIT;
          end
        end

        ST_TX_WAIT: begin
          tx_start <= 1'b0;
          // tx_done may still read idle the cycle after start; skip it once.
          if (tx_skip) begin
            tx_skip <= 1'b0;
          end else if (tx_done) begin
            state <= more_tx ? ST_TX_BYTE : ST_RECV;
          end
        end

        ST_RECV: begin
          if (rx_edge) begin
            rsp_data <= rsp_ins;
            rx_cnt   <= rx_cnt + CNT_W'(1);
            if (rx_cnt == n_bytes - CNT_W'(1)) begin
              state        <= ST_DONE;
              rsp_valid    <= 1'b1;
              rsp_mismatch <= mismatch_now;
            end
          end else if (tmr_expired) begin
            state       <= ST_DONE;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comm_host.sv
// Bench for comm_host: uart_tx/uart_rx behavioural models plus a frame-level reference of the protocol.
module tb_comm_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_error;
  logic        rsp_mismatch;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b1;
  logic        rx_ready;
  logic [7:0]  rx_data;

  int checks = 0;
  int errors = 0;

`ifdef COMM_HOST_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  comm_host #(
    .OUTPUT_COUNT  (16),
    .INPUT_COUNT   (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .rsp_error   (rsp_error),
    .rsp_mismatch(rsp_mismatch),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data)
  );

  always #5 clk = ~clk;

  // uart_tx model: captures each started byte, then stays busy a random number of cycles.
  logic [7:0] tx_q[$];
  int         tx_starts = 0;
  int         busy = 0;

  always @(posedge clk) begin
    #1;
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_starts++;
      busy = $urandom_range(0, 4);
      if (busy > 0) tx_done = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) tx_done = 1'b1;
    end
  end

  function automatic int nbytes(input logic [2:0] op);
    return (op == 3'd1 || op == 3'd3) ? 2 : 4;
  endfunction

  function automatic bit is_wr(input logic [2:0] op);
    return (op == 3'd3 || op == 3'd4);
  endfunction

  task automatic do_txn(input string name, input logic [2:0] op, input logic [31:0] data,
                        input logic [31:0] rxw, input int nrx, output int lat);
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rsp;
    logic [31:0] mask;
    bit          exp_to, exp_mm, got, ok;
    int          n;
    n = nbytes(op);
    exp_tx.push_back({5'b0, op});
    if (is_wr(op)) for (int k = 0; k < n; k++) exp_tx.push_back(data[8*k +: 8]);
    exp_rsp = '0;
    for (int k = 0; k < nrx && k < n; k++) exp_rsp[8*k +: 8] = rxw[8*k +: 8];
    exp_to = (nrx < n);
    mask   = (n == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    exp_mm = VERIFY && is_wr(op) && !exp_to && ((exp_rsp & mask) != (data & mask));
    tx_q.delete();
    lat = 0;

    req_valid = 1'b1; req_op = op; req_data = data;
    @(negedge clk);
    req_valid = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_q.size() >= exp_tx.size()) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || tx_q.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL %s tx_count: got %0d expected %0d", name, tx_q.size(), exp_tx.size());
    end
    for (int k = 0; k < exp_tx.size() && k < tx_q.size(); k++) begin
      checks++;
      if (tx_q[k] !== exp_tx[k]) begin
        errors++;
        $display("FAIL %s tx_byte%0d: got %02h expected %02h", name, k, tx_q[k], exp_tx[k]);
      end
    end

    for (int i = 0; i < 50 && tx_done !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);

    for (int k = 0; k < nrx; k++) begin
      rx_data  = rxw[8*k +: 8];
      rx_ready = 1'b1;
      if (k < nrx - 1) begin
        @(negedge clk);
        rx_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    got = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      rx_ready = 1'b0;
      if (rsp_valid === 1'b1) begin lat = i; got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s rsp_valid: got none within 400 cycles expected a strobe", name);
    end else begin
      checks++;
      if (rsp_data !== exp_rsp) begin
        errors++;
        $display("FAIL %s rsp_data: got %08h expected %08h", name, rsp_data, exp_rsp);
      end
      checks++;
      if ({rsp_timeout, rsp_error, rsp_mismatch} !== {exp_to, 1'b0, exp_mm}) begin
        errors++;
        $display("FAIL %s flags(to,err,mm): got %b expected %b", name,
                 {rsp_timeout, rsp_error, rsp_mismatch}, {exp_to, 1'b0, exp_mm});
      end
      checks++;
      if (!exp_to && lat != 1) begin
        errors++;
        $display("FAIL %s rsp_latency: got %0d expected 1", name, lat);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s ready_during_rsp: got %b expected 0", name, req_ready);
      end
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
        errors++;
        $display("FAIL %s ready_after_rsp(ready,valid): got %b expected 10", name, {req_ready, rsp_valid});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_data = '0; rx_ready = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_timeout, rsp_error, rsp_mismatch, tx_start} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000",
                         {rsp_valid, rsp_timeout, rsp_error, rsp_mismatch, tx_start});
    end
    checks++;
    if ({rsp_data, tx_data} !== 40'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {rsp_data, tx_data});
    end
  endtask

  task automatic test_write_mask();
    int lat;
    do_txn("write_mask", 3'd3, 32'h0000_A55A, 32'h0000_A55A, 2, lat);
  endtask

  task automatic test_read_map();
    int lat;
    do_txn("read_map", 3'd2, $urandom, 32'h1122_3344, 4, lat);
  endtask

  task automatic test_timeout();
    int lat;
    do_txn("timeout", 3'd1, 32'h0, 32'h0000_007F, 1, lat);
    checks++;
    if (lat != 101) begin
      errors++; $display("FAIL timeout_latency: got %0d negedges after strobe expected 101", lat);
    end
  endtask

  task automatic test_reject();
    logic [2:0] bad_ops[4];
    int         starts0, lat;
    bad_ops = '{3'd0, 3'd5, 3'd6, 3'd7};
    foreach (bad_ops[j]) begin
      starts0   = tx_starts;
      req_valid = 1'b1; req_op = bad_ops[j]; req_data = $urandom;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_error, req_ready} !== 3'b110) begin
        errors++; $display("FAIL reject_op%0d_rsp(valid,err,ready): got %b expected 110",
                           bad_ops[j], {rsp_valid, rsp_error, req_ready});
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
        errors++; $display("FAIL reject_op%0d_after(valid,ready): got %b expected 01",
                           bad_ops[j], {rsp_valid, req_ready});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (tx_starts != starts0) begin
        errors++; $display("FAIL reject_op%0d_tx: got %0d starts expected 0", bad_ops[j], tx_starts - starts0);
      end
    end
    rx_data = 8'hEE; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    do_txn("after_stray_rx", 3'd1, 32'h0, 32'h0000_1234, 2, lat);
  endtask

  task automatic test_mismatch();
    int lat;
    do_txn("verify_map", 3'd4, 32'h0123_4567, 32'h0123_4566, 4, lat);
  endtask

  task automatic test_reset_mid();
    int  starts0, lat;
    bit  ok, seen;
    tx_q.delete();
    req_valid = 1'b1; req_op = 3'd4; req_data = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_q.size() >= 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midrst_payload: got %0d bytes expected 3", tx_q.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, tx_start, rsp_timeout, rsp_error, rsp_mismatch} !== 6'b100000 ||
        {rsp_data, tx_data} !== 40'h0) begin
      errors++; $display("FAIL midrst_outputs: got %b/%h expected 100000/0",
                         {req_ready, rsp_valid, tx_start, rsp_timeout, rsp_error, rsp_mismatch},
                         {rsp_data, tx_data});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50 && tx_done !== 1'b1; i++) @(negedge clk);
    starts0 = tx_starts;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || tx_starts != starts0) begin
      errors++; $display("FAIL midrst_quiet: got valid=%b starts=%0d expected 0 and 0", seen, tx_starts - starts0);
    end
    do_txn("after_midrst", 3'd1, 32'h0, 32'h0000_BEEF, 2, lat);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] data, rxw;
    int          n, nrx, lat;
    for (int i = 0; i < 16; i++) begin
      op   = 3'($urandom_range(1, 4));
      data = $urandom;
      n    = nbytes(op);
      rxw  = is_wr(op) ? data : $urandom;
      if (is_wr(op) && ($urandom % 3 == 0)) rxw = rxw ^ (32'h1 << $urandom_range(0, 8*n - 1));
      nrx  = ($urandom % 6 == 0) ? n - 1 : n;
      do_txn("random", op, data, rxw, nrx, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_mask();
    test_read_map();
    test_timeout();
    test_reject();
    test_mismatch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
